// File: rtl/pp_fifo_reader.sv
// Prefetching reader for a FIFO with a one-cycle read latency.
// A two-entry skid buffer turns the FIFO read port into a valid/ready stream.
module pp_fifo_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_do,
  output logic              fifo_re,
  input  logic              flush,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  pop_count
);

  // state | meaning
  // EMPTY | no byte held, m_valid low
  // ONE   | head holds the byte on m_data
  // TWO   | head and tail both hold bytes; no further reads until a pop
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t              occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  pop_count_q, pop_count_d;
  logic [1:0]        run_q, run_d;

  logic       pop;
  logic       cap;
  logic [2:0] used;

  // run_q[1] rises two edges after reset release, so the first cycle never reads
  assign run_d = {run_q[0], 1'b1};

  assign pop  = (occ_q != EMPTY) & m_ready & ~flush;
  assign cap  = inflight_q & ~flush;
  assign used = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

  assign fifo_re   = run_q[1] & ~fifo_empty & ~flush & (used < 3'd2);
  assign m_valid   = (occ_q != EMPTY);
  assign m_data    = head_q;
  assign pop_count = pop_count_q;

  always_comb begin
    occ_d       = occ_q;
    head_d      = head_q;
    tail_d      = tail_q;
    inflight_d  = fifo_re;
    pop_count_d = pop ? pop_count_q + CNT_W'(1) : pop_count_q;
    if (flush) begin
      occ_d = EMPTY;
    end else begin
      case ({pop, cap})
        2'b10: begin
          head_d = tail_q;
          occ_d  = (occ_q == TWO) ? ONE : EMPTY;
        end
        2'b01: begin
          if (occ_q == EMPTY) begin
            head_d = fifo_do;
            occ_d  = ONE;
          end else begin
            tail_d = fifo_do;
            occ_d  = TWO;
          end
        end
        2'b11: begin
          // pop and capture together: occupancy is unchanged, data slides up
          if (occ_q == TWO) begin
            head_d = tail_q;
            tail_d = fifo_do;
          end else begin
            head_d = fifo_do;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      inflight_q  <= 1'b0;
      pop_count_q <= '0;
      run_q       <= 2'b00;
    end else begin
      occ_q       <= occ_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      inflight_q  <= inflight_d;
      pop_count_q <= pop_count_d;
      run_q       <= run_d;
    end
  end

endmodule

// File: tb/tb_pp_fifo_reader.sv
// Directed bench for pp_fifo_reader with a behavioural one-cycle-latency FIFO.
module tb_pp_fifo_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_do = 8'h00;
  logic        fifo_re;
  logic        flush;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] pop_count;

  pp_fifo_reader #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_do(fifo_do),
    .fifo_re(fifo_re), .flush(flush), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .pop_count(pop_count)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:255];
  int unsigned rd_ptr = 0;
  int unsigned wr_ptr = 0;
  bit          gen_mode = 1'b0;
  bit          hold_empty = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) || hold_empty;

  always @(posedge clk) begin
    if (fifo_re) begin
      fifo_do <= gen_mode ? rd_ptr[7:0] : mem[rd_ptr[7:0]];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  logic [7:0] got [$];
  int         got_cyc [$];
  int         re_cnt = 0;
  int         bad_re = 0;
  int         cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (fifo_re && fifo_empty) bad_re++;
    if (rst_n) begin
      if (m_valid && m_ready && !flush) begin
        got.push_back(m_data);
        got_cyc.push_back(cyc);
      end
      if (fifo_re) re_cnt++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    int k = 0;
    while (got.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, (got.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q [$];
    int k;
    int errs;
    int pushed;

    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
    tick(3);
    check("rst_fifo_re", fifo_re, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_pop_count", pop_count, 0);

    // Three preloaded bytes, streamed back to back
    push(8'h11); push(8'h22); push(8'h33);
    m_ready = 1'b1;
    rst_n = 1'b1;
    tick(1);
    check("no_re_after_release", fifo_re, 0);
    wait_got(3, 50, "t1_timeout");
    tick(3);
    check("t1_b0", got[0], 8'h11);
    check("t1_b1", got[1], 8'h22);
    check("t1_b2", got[2], 8'h33);
    check("t1_consecutive", got_cyc[2] - got_cyc[0], 2);
    check("t1_pop_count", pop_count, 3);
    check("t1_re_cycles", re_cnt, 3);

    // Backpressure: only two reads while stalled, first byte held
    got.delete(); got_cyc.delete();
    m_ready = 1'b0; re_cnt = 0;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    tick(1);
    check("t2_valid_lat1", m_valid, 0);
    tick(1);
    check("t2_valid_lat2", m_valid, 1);
    tick(8);
    check("t2_re_cycles", re_cnt, 2);
    check("t2_hold_valid", m_valid, 1);
    check("t2_hold_data", m_data, 8'hA1);
    m_ready = 1'b1;
    wait_got(4, 50, "t2_timeout");
    tick(3);
    check("t2_b0", got[0], 8'hA1);
    check("t2_b1", got[1], 8'hA2);
    check("t2_b2", got[2], 8'hA3);
    check("t2_b3", got[3], 8'hA4);
    check("t2_pop_count", pop_count, 7);
    check("t2_re_total", re_cnt, 4);

    // Flush while B3 is in flight
    got.delete(); got_cyc.delete();
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4); push(8'hB5); push(8'hB6);
    tick(3);
    check("t3_pre_valid", m_valid, 1);
    check("t3_pre_data", m_data, 8'hB2);
    flush = 1'b1; m_ready = 1'b0;
    #1;
    check("t3_flush_no_re", fifo_re, 0);
    tick(1);
    flush = 1'b0; m_ready = 1'b1;
    check("t3_valid_dropped", m_valid, 0);
    wait_got(4, 50, "t3_timeout");
    tick(5);
    check("t3_count", got.size(), 4);
    check("t3_b0", got[0], 8'hB1);
    check("t3_b1", got[1], 8'hB4);
    check("t3_b3", got[3], 8'hB6);
    check("t3_pop_count", pop_count, 11);

    // Reset while holding two bytes
    got.delete(); got_cyc.delete();
    m_ready = 1'b0; re_cnt = 0;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hC5);
    tick(6);
    check("t4_two_reads", re_cnt, 2);
    check("t4_pre_data", m_data, 8'hC1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_re", fifo_re, 0);
    check("t4_rst_valid", m_valid, 0);
    check("t4_rst_data", m_data, 0);
    check("t4_rst_count", pop_count, 0);
    tick(2);
    rst_n = 1'b1; m_ready = 1'b1;
    wait_got(3, 50, "t4_timeout");
    tick(3);
    check("t4_b0", got[0], 8'hC3);
    check("t4_b1", got[1], 8'hC4);
    check("t4_b2", got[2], 8'hC5);
    check("t4_pop_count", pop_count, 3);

    // Counter wrap: 65531 more handshakes brings 3 to 0xFFFE
    gen_mode = 1'b1;
    wr_ptr = wr_ptr + 65531;
    k = 0;
    while (pop_count != 16'hFFFE && k < 70000) begin
      tick(1);
      k++;
    end
    check("t5_throughput", (k <= 65535) ? 32'd1 : 32'd0, 32'd1);
    tick(10);
    check("t5_fffe", pop_count, 16'hFFFE);
    wr_ptr = wr_ptr + 2;
    tick(10);
    check("t5_wrap", pop_count, 16'h0000);
    check("t5_idle", m_valid, 0);
    gen_mode = 1'b0;
    got.delete(); got_cyc.delete();

    // Random empty flag and backpressure
    pushed = 0;
    k = 0;
    while (got.size() < 40 && k < 2000) begin
      if (pushed < 40 && $urandom_range(1, 0) == 1) begin
        exp_q.push_back(8'($urandom_range(255, 0)));
        push(exp_q[pushed]);
        pushed++;
      end
      hold_empty = ($urandom_range(1, 0) == 1);
      m_ready = ($urandom_range(1, 0) == 1);
      tick(1);
      k++;
    end
    hold_empty = 1'b0; m_ready = 1'b1;
    while (pushed < 40) begin
      exp_q.push_back(8'($urandom_range(255, 0)));
      push(exp_q[pushed]);
      pushed++;
    end
    wait_got(40, 200, "t6_timeout");
    tick(5);
    check("t6_count", got.size(), 40);
    errs = 0;
    for (int i = 0; i < 40 && i < got.size(); i++)
      if (got[i] !== exp_q[i]) errs++;
    check("t6_order", errs, 0);
    check("no_re_when_empty", bad_re, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pp_fifo_reader.md
PP_FIFO_READER -- requirements
Module: pp_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning byte-lane width of the FIFO read port and the output stream.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the handshake counter.
REQ-003 SHALL have port clk, input, 1, the single clock shared with the FIFO read side.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-006 SHALL have port fifo_do, input, DATA_W, FIFO read data, valid one cycle after fifo_re (unregistered read).
REQ-007 SHALL have port fifo_re, output, 1, FIFO read enable.
REQ-008 SHALL have port flush, input, 1, discard all held and in-flight data.
REQ-009 SHALL have port m_data, output, DATA_W, output stream data.
REQ-010 SHALL have port m_valid, output, 1, m_data holds a valid byte.
REQ-011 SHALL have port m_ready, input, 1, downstream accepts the byte.
REQ-012 SHALL have port pop_count, output, CNT_W, number of completed output handshakes.

Function
REQ-013 SHALL hold a 2-entry skid buffer (head, tail) and a 1-bit in-flight flag marking that the previous cycle's fifo_re returned data this cycle.
REQ-014 SHALL assert fifo_re in a cycle only when fifo_empty=0, flush=0, and (buffer occupancy + in-flight + pending pop adjustment) < 2, where an output handshake in the same cycle frees one slot.
REQ-015 SHALL never assert fifo_re while fifo_empty=1.
REQ-016 SHALL capture fifo_do into the first free buffer slot in the cycle after fifo_re=1, unless flush was or is asserted.
REQ-017 SHALL drive m_valid=1 whenever occupancy>=1 and m_data = head entry, registered.
REQ-018 SHALL, on m_valid=1 & m_ready=1, pop the head; tail shifts to head in the same edge; simultaneous capture writes to the correct resulting slot.
REQ-019 SHALL keep m_data stable while m_valid=1 & m_ready=0 (AXI-style hold).
REQ-020 SHALL sustain one byte per cycle when fifo_empty=0 and m_ready=1 continuously, after initial latency of 2 cycles from fifo_empty falling to m_valid rising.
REQ-021 SHALL, when flush=1, clear occupancy to 0, drop m_valid the next edge, suppress fifo_re, and discard data returning from a read issued the cycle before flush.
REQ-022 SHALL not count handshakes discarded by flush; pop_count increments by 1 per handshake and wraps from 2^CNT_W-1 to 0.
REQ-023 SHALL treat occupancy as state EMPTY(0)/ONE(1)/TWO(2); TWO with m_ready=0 SHALL deassert fifo_re; no occupancy above 2 SHALL be reachable.

Reset
REQ-024 SHALL, while rst_n=0, force fifo_re=0, m_valid=0, m_data=0, pop_count=0, occupancy=0, in-flight=0 asynchronously.
REQ-025 SHALL release reset synchronously to clk internally and issue no fifo_re in the first cycle after release.
REQ-026 SHALL discard any read in flight when reset asserts mid-operation.

Verification
REQ-027 Bench: FIFO preloaded 0x11,0x22,0x33, m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles, pop_count=3, fifo_re exactly 3 cycles high.
REQ-028 Bench: 4 bytes available, m_ready=0 for 10 cycles -> fifo_re high exactly 2 cycles, m_data=first byte held, then m_ready=1 delivers all 4 in order.
REQ-029 Bench: flush pulse 1 cycle during streaming with read in flight -> m_valid=0 next cycle, in-flight byte never appears, pop_count unchanged by dropped bytes.
REQ-030 Bench: rst_n low mid-stream with occupancy TWO -> all outputs 0 immediately; after release first output byte is next unread FIFO entry.
REQ-031 Bench: pop_count preset to 0xFFFE via 0xFFFE handshakes, 2 more -> pop_count=0x0000.
REQ-032 Bench: fifo_empty toggling randomly with random m_ready -> fifo_re never high while fifo_empty=1, output order equals FIFO order, no loss or duplication.
